// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and future
// read-side schedulers.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int BURST_CNT_W = 8;
    localparam int MAX_REQ     = 16;

    // Wide enough for the largest supported requester count; callers slice.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after
// last_idx, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_idx,
    output logic             found,
    output logic [ID_W-1:0]  next_idx
);

    logic [ID_W:0]      start;
    logic [ID_W:0]      sum;
    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [ID_W-1:0]    offset;

    // Rotate so the search origin lands on bit 0, priority-encode the lowest
    // set bit, then rotate the winning offset back into an absolute index.
    always_comb begin
        start    = (last_idx >= ID_W'(N_REQ - 1)) ? '0 : {1'b0, last_idx} + 1'b1;
        doubled  = {req, req} >> start;
        rotated  = doubled[N_REQ-1:0];
        found    = |req;
        offset   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = ID_W'(k);
            end
        end
        sum      = start + {1'b0, offset};
        next_idx = (sum >= (ID_W + 1)'(N_REQ)) ? ID_W'(sum - (ID_W + 1)'(N_REQ))
                                               : ID_W'(sum);
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among
// N_REQ producers; the grant rotates only through an IDLE cycle.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int D_WIDTH   = 8,
    parameter int MAX_BURST = 4,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*D_WIDTH-1:0]   data_in_flat,
    output logic [N_REQ-1:0]           ack,
    input  logic                       fifo_full,
    output logic                       fifo_w_en,
    output logic [D_WIDTH-1:0]         fifo_data,
    output logic [ID_W-1:0]            grant_id,
    output logic                       busy
);

    arb_state_t               state;
    logic [BURST_CNT_W-1:0]   burst_cnt;
    logic                     pick_found;
    logic [ID_W-1:0]          pick_idx;
    logic                     owner_req;
    logic                     last_word;
    logic [MAX_REQ-1:0]       owner_onehot;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req      (req),
        .last_idx (grant_id),
        .found    (pick_found),
        .next_idx (pick_idx)
    );

    assign owner_req    = req[grant_id];
    assign owner_onehot = onehot(4'(grant_id));
    assign last_word    = (burst_cnt == BURST_CNT_W'(MAX_BURST - 1));

    // Outputs decode straight from the registered state, so an async reset
    // silences the write port within the same cycle.
    assign busy      = (state == BURST);
    assign fifo_w_en = busy & owner_req & ~fifo_full;
    assign ack       = fifo_w_en ? owner_onehot[N_REQ-1:0] : '0;
    assign fifo_data = busy ? data_in_flat[grant_id*D_WIDTH +: D_WIDTH] : '0;

    // A full FIFO simply stalls the burst; a dropped request always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            grant_id  <= ID_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id  <= pick_idx;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (!owner_req) begin
                        state <= IDLE;
                    end else if (fifo_w_en) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (last_word) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and random checks of fifo_write_arbiter against a queue-based
// producer/FIFO model and a plain round-robin burst model.
module tb_fifo_write_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] data_in_flat = '0;
    logic [N-1:0]    ack;
    logic            fifo_full = 1'b0;
    logic            fifo_w_en;
    logic [DW-1:0]   fifo_data;
    logic [1:0]      grant_id;
    logic            busy;

    logic [2:0]      req6 = '0;
    logic [23:0]     data6 = 24'hC2_B1_A0;
    logic [2:0]      ack6;
    logic            full6 = 1'b0;
    logic            wen6;
    logic [7:0]      fdata6;
    logic [1:0]      gid6;
    logic            busy6;

    fifo_write_arbiter #(.N_REQ(N), .D_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in_flat(data_in_flat),
        .ack(ack), .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
        .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy)
    );

    fifo_write_arbiter #(.N_REQ(3), .D_WIDTH(8), .MAX_BURST(1)) dut6 (
        .clk(clk), .rst_n(rst_n), .req(req6), .data_in_flat(data6),
        .ack(ack6), .fifo_full(full6), .fifo_w_en(wen6),
        .fifo_data(fdata6), .grant_id(gid6), .busy(busy6)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  fifo_q[$];
    logic [5:0]  tag[N];
    logic [5:0]  pop_tag[N];
    int          words_left[N];
    bit          rand_mode = 1'b0;
    bit          rd_en = 1'b1;
    bit          m_busy;
    int          m_owner;
    int          m_cnt;
    logic        s_wen;
    logic [N-1:0] s_ack;
    logic [7:0]  s_data;
    int          b_grant[$];
    int          b_writes[$];
    bit          prev_busy;
    int          cyc;
    logic [31:0] wmap;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            data_in_flat[i*DW +: DW] = {2'(i), tag[i]};
        end
        fifo_full = (fifo_q.size() == DEPTH);
    endtask

    // One clock: compare at the falling edge, then advance FIFO, model and producers.
    task automatic applyStimulus();
        logic exp_wen;
        logic [7:0] w;
        int p;
        @(negedge clk);
        exp_wen = m_busy && req[m_owner] && !fifo_full;
        check("busy", 32'(busy), 32'(m_busy));
        check("grant_id", 32'(grant_id), 32'(m_owner));
        check("w_en", 32'(fifo_w_en), 32'(exp_wen));
        check("ack", 32'(ack), exp_wen ? (32'd1 << m_owner) : 32'd0);
        if (exp_wen) begin
            check("data", 32'(fifo_data), 32'({2'(m_owner), tag[m_owner]}));
        end
        s_wen  = fifo_w_en;
        s_ack  = ack;
        s_data = fifo_data;
        if (busy && !prev_busy) begin
            b_grant.push_back(int'(grant_id));
            b_writes.push_back(0);
        end
        if (s_wen && b_writes.size() > 0) begin
            b_writes[b_writes.size()-1]++;
        end
        prev_busy = busy;
        if (s_wen && cyc < 32) wmap[cyc] = 1'b1;
        cyc++;
        @(posedge clk);
        #1;
        if (rd_en && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            p = int'(w[7:6]);
            check("order", 32'(w[5:0]), 32'(pop_tag[p]));
            pop_tag[p]++;
        end
        if (s_wen) fifo_q.push_back(s_data);
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                if (req[(m_owner + k) % N]) begin
                    m_owner = (m_owner + k) % N;
                    m_busy  = 1'b1;
                    m_cnt   = 0;
                    break;
                end
            end
        end else if (!req[m_owner]) begin
            m_busy = 1'b0;
        end else if (s_wen) begin
            m_cnt++;
            if (m_cnt == MB) m_busy = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (s_ack[i]) begin
                tag[i]++;
                if (!rand_mode) words_left[i]--;
            end
            if (rand_mode) begin
                if (s_ack[i]) req[i] = 1'($urandom_range(0, 1));
                else if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
            end else begin
                req[i] = (words_left[i] > 0);
            end
        end
        if (rand_mode) rd_en = ($urandom_range(0, 3) != 0);
        drive_inputs();
    endtask

    task automatic checkOutput(input string name);
        check({name, "_w_en"}, 32'(fifo_w_en), 32'd0);
        check({name, "_ack"}, 32'(ack), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_grant"}, 32'(grant_id), 32'd3);
    endtask

    task automatic clear_bench();
        req = '0;
        req6 = '0;
        for (int i = 0; i < N; i++) begin
            tag[i] = '0;
            pop_tag[i] = '0;
            words_left[i] = 0;
        end
        fifo_q.delete();
        b_grant.delete();
        b_writes.delete();
        m_busy = 1'b0;
        m_owner = N - 1;
        m_cnt = 0;
        prev_busy = 1'b0;
        rd_en = 1'b1;
        rand_mode = 1'b0;
        cyc = 0;
        wmap = '0;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_bench();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        check("reset_data", 32'(fifo_data), 32'd0);
        check("reset_gid6", 32'(gid6), 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int wr;
        logic [2:0] exp6[8];
        exp6 = '{3'b000, 3'b001, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b100};

        // Single producer, six words: 4-word burst, one idle cycle, 2 more words.
        do_reset();
        words_left[0] = 6;
        req = 4'b0001;
        drive_inputs();
        repeat (10) applyStimulus();
        check("s1_write_map", wmap, 32'h0000_00DE);
        check("s1_ack_count", 32'(tag[0]), 32'd6);

        // All producers requesting: grants rotate 0,1,2,3,0 with 4 writes each.
        do_reset();
        for (int i = 0; i < N; i++) words_left[i] = 8;
        req = 4'b1111;
        drive_inputs();
        repeat (30) applyStimulus();
        check("s2_bursts", 32'(b_grant.size() >= 5), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < b_grant.size()) check("s2_grant_order", 32'(b_grant[k]), 32'(k % N));
            if (k < 4 && k < b_writes.size()) check("s2_burst_len", 32'(b_writes[k]), 32'd4);
        end

        // FIFO fills: writes stall, grant holds; one read lets exactly one word in.
        do_reset();
        for (int i = 0; i < N; i++) words_left[i] = 10;
        req = 4'b1111;
        rd_en = 1'b0;
        drive_inputs();
        n = 0;
        while (fifo_q.size() < DEPTH && n < 40) begin
            applyStimulus();
            n++;
        end
        check("s3_filled", 32'(fifo_q.size()), 32'(DEPTH));
        wr = 0;
        repeat (5) begin
            applyStimulus();
            if (s_wen) wr++;
        end
        check("s3_full_writes", 32'(wr), 32'd0);
        check("s3_grant", 32'(grant_id), 32'd2);
        check("s3_busy", 32'(busy), 32'd1);
        rd_en = 1'b1;
        applyStimulus();
        rd_en = 1'b0;
        wr = 0;
        repeat (4) begin
            applyStimulus();
            if (s_wen) wr++;
        end
        check("s3_one_write", 32'(wr), 32'd1);
        check("s3_grant_after", 32'(grant_id), 32'd2);
        rd_en = 1'b1;
        repeat (30) applyStimulus();

        // Owner drops after two words; next grant goes to producer 3.
        do_reset();
        words_left[2] = 2;
        words_left[3] = 3;
        req = 4'b1100;
        drive_inputs();
        repeat (14) applyStimulus();
        check("s4_bursts", 32'(b_grant.size()), 32'd2);
        if (b_grant.size() >= 2) begin
            check("s4_first_grant", 32'(b_grant[0]), 32'd2);
            check("s4_first_len", 32'(b_writes[0]), 32'd2);
            check("s4_second_grant", 32'(b_grant[1]), 32'd3);
            check("s4_second_len", 32'(b_writes[1]), 32'd3);
        end

        // Asynchronous reset mid-burst, then first grant after release.
        do_reset();
        words_left[1] = 10;
        req = 4'b0010;
        drive_inputs();
        repeat (3) applyStimulus();
        #2;
        check("s5_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("s5_async");
        clear_bench();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        words_left[3] = 1;
        req = 4'b1000;
        drive_inputs();
        n = 0;
        while (n < 8) begin
            applyStimulus();
            n++;
            if (s_ack[3]) break;
        end
        check("s5_latency", 32'(n), 32'd2);
        check("s5_grant", 32'(b_grant.size() > 0 ? b_grant[0] : -1), 32'd3);

        // Three requesters, single-word bursts: writes alternate 0,2,0,2.
        do_reset();
        req6 = 3'b101;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("s6_ack", 32'(ack6), 32'(exp6[k]));
            if (exp6[k] == 3'b001) check("s6_data", 32'(fdata6), 32'hA0);
            if (exp6[k] == 3'b100) check("s6_data", 32'(fdata6), 32'hC2);
            @(posedge clk);
            #1;
        end
        req6 = '0;

        // Random producer traffic with random FIFO draining.
        do_reset();
        rand_mode = 1'b1;
        for (int i = 0; i < N; i++) req[i] = 1'($urandom_range(0, 1));
        drive_inputs();
        repeat (400) applyStimulus();
        rand_mode = 1'b0;
        rd_en = 1'b1;
        repeat (40) applyStimulus();
        check("s7_drained", 32'(fifo_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
